// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: opcode decode,
// per-state datapath controls, retired-instruction count and illegal flag.
module mips_multicycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               irwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsource,
  output logic [1:0]         aluop,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // ALU operation codes handed to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_X     = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  // Ungated write-enable decodes; reset forces these low below
  logic pcwrite_c;
  logic pcwritecond_c;
  logic irwrite_c;
  logic regwrite_c;
  logic memwrite_c;
  logic illegal_c;
  logic retire_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^COUNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (retire_c) begin
      instr_count <= instr_count + COUNT_W'(1);
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = S_FETCH;
    pcwrite_c     = 1'b0;
    pcwritecond_c = 1'b0;
    irwrite_c     = 1'b0;
    regwrite_c    = 1'b0;
    memwrite_c    = 1'b0;
    illegal_c     = 1'b0;
    retire_c      = 1'b0;
    iord          = 1'b0;
    memread       = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = SRCB_REG;
    pcsource      = PCSRC_ALU;
    aluop         = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = SRCB_FOUR;
        aluop     = ALUOP_ADD;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alusrcb = SRCB_IMM2;
        aluop   = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
        // opcode is held stable, so only lw/sw normally reach here
        case (opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_ILLEGAL;
        endcase
      end

      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        regdst     = 1'b0;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord       = 1'b1;
        retire_c   = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REG;
        aluop   = ALUOP_FUNCT;
        state_d = S_RWB;
      end

      S_RWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
        memtoreg   = 1'b0;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alusrca       = 1'b1;
        alusrcb       = SRCB_REG;
        aluop         = ALUOP_SUB;
        pcwritecond_c = 1'b1;
        pcsource      = PCSRC_ALUOUT;
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pcwrite_c = 1'b1;
        pcsource  = PCSRC_JUMP;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      S_ILLEGAL: begin
        aluop     = ALUOP_X;
        illegal_c = 1'b1;
        state_d   = S_FETCH;
      end

      // Unreachable encodings: all outputs stay at their zero defaults
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables and the illegal flag are held low while reset is asserted
  assign pcwrite     = pcwrite_c     & rst_n;
  assign pcwritecond = pcwritecond_c & rst_n;
  assign irwrite     = irwrite_c     & rst_n;
  assign regwrite    = regwrite_c    & rst_n;
  assign memwrite    = memwrite_c    & rst_n;
  assign illegal     = illegal_c     & rst_n;

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-instruction expected
// cycle traces are expanded from the opcode and memory stall pattern.
module tb_mips_multicycle_control;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
  logic          irwrite, regwrite, regdst, alusrca, illegal;
  logic [1:0]    alusrcb, pcsource, aluop;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  typedef struct packed {
    logic [3:0]    st;
    logic          pcwrite;
    logic          pcwritecond;
    logic          iord;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          irwrite;
    logic          regwrite;
    logic          regdst;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [1:0]    pcsource;
    logic [1:0]    aluop;
    logic          illegal;
    logic [CW-1:0] cnt;
  } obs_t;

  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  int   ill_seen = 0;
  logic chk_en = 1'b0;
  obs_t exp_o;
  string exp_name = "";
  logic [CW-1:0] mcnt = '0;

  mips_multicycle_control #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Control values listed for each state; unlisted signals are 0
  function automatic obs_t exp_of(input int st, input logic mr, input logic [CW-1:0] c);
    obs_t o;
    o = '0;
    o.st  = 4'(st);
    o.cnt = c;
    case (st)
      0:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      1:  begin o.alusrcb = 2'b11; end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; end
      6:  begin o.alusrca = 1; o.aluop = 2'b10; end
      7:  begin o.regwrite = 1; o.regdst = 1; end
      8:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcwritecond = 1; o.pcsource = 2'b01; end
      9:  begin o.pcwrite = 1; o.pcsource = 2'b10; end
      10: begin o.aluop = 2'b11; o.illegal = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Compare DUT outputs against the expected record on every active cycle
  always @(negedge clk) begin
    if (chk_en) begin
      obs_t act;
      act = {state, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
             irwrite, regwrite, regdst, alusrca, alusrcb, pcsource, aluop,
             illegal, instr_count};
      total++;
      if (act !== exp_o) begin
        bad++;
        $display("FAIL %s: got %h want %h", exp_name, act, exp_o);
      end
      if (illegal === 1'b1) ill_seen++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // One clock cycle: drive mem_ready, publish expectation, advance
  task automatic cyc(input string nm, input int st, input logic mr);
    mem_ready = mr;
    exp_o     = exp_of(st, mr, mcnt);
    exp_name  = nm;
    chk_en    = 1'b1;
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycle trace
  task automatic run(input logic [5:0] op, input int fst, input int mst);
    bit retires;
    opcode  = op;
    retires = 1;
    for (int i = 0; i < fst; i++) cyc("fetch_wait", 0, 1'b0);
    cyc("fetch", 0, 1'b1);
    cyc("decode", 1, rnd_bit());
    case (op)
      6'b100011: begin
        cyc("memadr_lw", 2, rnd_bit());
        for (int i = 0; i < mst; i++) cyc("memrd_wait", 3, 1'b0);
        cyc("memrd", 3, 1'b1);
        cyc("memwb", 4, rnd_bit());
      end
      6'b101011: begin
        cyc("memadr_sw", 2, rnd_bit());
        for (int i = 0; i < mst; i++) cyc("memwr_wait", 5, 1'b0);
        cyc("memwr", 5, 1'b1);
      end
      6'b000000: begin
        cyc("exec", 6, rnd_bit());
        cyc("rwb", 7, rnd_bit());
      end
      6'b000100: cyc("branch", 8, rnd_bit());
      6'b000010: cyc("jump", 9, rnd_bit());
      default: begin
        cyc("illegal", 10, rnd_bit());
        retires = 0;
      end
    endcase
    if (retires) mcnt = mcnt + CW'(1);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b0;
    mem_ready = 1'b1;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_pcwrite", 32'(pcwrite), 32'd0);
    chk("rst_irwrite", 32'(irwrite), 32'd0);
    chk("rst_memread", 32'(memread), 32'd1);
    chk("rst_alusrcb", 32'(alusrcb), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw, no stalls
    ncyc = 0;
    run(6'b100011, 0, 0);
    chk("lw_cycles", 32'(ncyc), 32'd5);
    chk("lw_count", 32'(instr_count), 32'd1);

    // Reset while a store is stalled in MEMWR
    opcode = 6'b101011;
    cyc("fetch", 0, 1'b1);
    cyc("decode", 1, 1'b1);
    cyc("memadr_sw", 2, 1'b1);
    chk_en    = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("memwr_memwrite", 32'(memwrite), 32'd1);
    chk("memwr_state", 32'(state), 32'd5);
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("abort_memwrite", 32'(memwrite), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", 32'(instr_count), 32'd0);
    chk("abort_pcwrite", 32'(pcwrite), 32'd0);
    chk("abort_irwrite", 32'(irwrite), 32'd0);
    chk("abort_memread", 32'(memread), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = '0;

    // R-type followed by beq
    ncyc = 0;
    run(6'b000000, 0, 0);
    run(6'b000100, 0, 0);
    chk("r_beq_cycles", 32'(ncyc), 32'd7);
    chk("r_beq_count", 32'(instr_count), 32'd2);

    // sw with three wait cycles in MEMWR
    ncyc = 0;
    run(6'b101011, 0, 3);
    chk("sw_stall_cycles", 32'(ncyc), 32'd7);
    chk("sw_stall_count", 32'(instr_count), 32'd3);

    // Unsupported addi
    ncyc = 0;
    ill_seen = 0;
    run(6'b001000, 0, 0);
    chk("addi_cycles", 32'(ncyc), 32'd3);
    chk_en = 1'b0;
    chk("addi_illegal_pulses", 32'(ill_seen), 32'd1);
    chk("addi_count", 32'(instr_count), 32'd3);

    // Fetch and memory-read stalls, then an illegal with fetch stall
    ncyc = 0;
    run(6'b100011, 2, 1);
    chk("lw_stall_cycles", 32'(ncyc), 32'd8);
    run(6'b111111, 1, 0);
    chk("lw_stall_count", 32'(instr_count), 32'd4);

    // Sixteen jumps wrap the 4-bit counter back to zero
    do_reset();
    for (int k = 0; k < 16; k++) run(6'b000010, 0, 0);
    chk_en = 1'b0;
    chk("jump_wrap_count", 32'(instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of the 2-bit `aluop` code consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use funct, 11 = unknown/ALU-x. It also counts retired instructions and flags illegal opcodes.

## Interface
- `COUNT_W`, default 32, width of retired-instruction counter.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 6: IR[31:26]; stable from DECODE until return to FETCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca` out 1: datapath controls.
- `alusrcb` out 2: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `pcsource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: to ALU control.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state encoding, for debug.
- `instr_count` out COUNT_W: retired instructions.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. Every other opcode is illegal.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ILLEGAL=10
  - Codes 11-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Outputs are a Moore decode of `state`. `irwrite`, `pcwrite` in FETCH, and `memwrite` are additionally qualified as listed. Any signal not listed for a state is 0.
- FETCH:
  - Drives `memread`=1, `alusrcb`=01, `aluop`=00.
  - Drives `irwrite`=`pcwrite`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE:
  - Drives `alusrcb`=11, `aluop`=00.
  - Next state: lw/sw -> MEMADR, R -> EXEC, beq -> BRANCH, j -> JUMP, else -> ILLEGAL.
- MEMADR: drives `alusrca`=1, `alusrcb`=10, `aluop`=00. Goes to MEMRD on lw, MEMWR on sw.
- MEMRD: drives `memread`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: drives `regwrite`=1, `memtoreg`=1, `regdst`=0. Goes to FETCH.
- MEMWR: drives `memwrite`=1, `iord`=1 for every cycle in the state. Holds until `mem_ready`, then goes to FETCH.
- EXEC: drives `alusrca`=1, `alusrcb`=00, `aluop`=10. Goes to RWB.
- RWB: drives `regwrite`=1, `regdst`=1, `memtoreg`=0. Goes to FETCH.
- BRANCH: drives `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcwritecond`=1, `pcsource`=01. Goes to FETCH.
- JUMP: drives `pcwrite`=1, `pcsource`=10. Goes to FETCH.
- ILLEGAL: drives `aluop`=11, `illegal`=1, all write enables 0. Goes to FETCH.
- `instr_count` increments by 1 on each retiring edge, wrapping modulo 2^COUNT_W:
  - leaving MEMWB, RWB, BRANCH or JUMP;
  - leaving MEMWR with `mem_ready`=1.
  - ILLEGAL never retires.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Reset:
  - `rst_n` low asynchronously forces `state`=FETCH and `instr_count`=0.
  - While `rst_n` is low, force `pcwrite`, `pcwritecond`, `irwrite`, `regwrite`, `memwrite` and `illegal` to 0.
  - Other outputs show FETCH values during reset: `memread`=1, `alusrcb`=01, remaining 0.
- Reset asserted mid-instruction aborts it: no retire count and no further writes.
- After `rst_n` deasserts, the first rising edge evaluates FETCH normally.
- Cycle counts with `mem_ready` tied high: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 3.
- Each low-`mem_ready` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `illegal` is high for exactly one cycle, the ILLEGAL cycle, i.e. the third cycle of the sequence.
- `opcode` is sampled in DECODE and MEMADR only.

## Test plan
- Reset mid-MEMWR (`memwrite`=1): on `rst_n`=0, `memwrite` drops to 0 without a clock; `state`=0; `instr_count`=0.
- lw, `mem_ready`=1: states 0,1,2,3,4,0. `aluop` 00 in MEMADR; `regwrite`=`memtoreg`=1 only in state 4; `instr_count` 0 -> 1.
- R-type then beq: EXEC has `aluop`=10; RWB has `regdst`=1. BRANCH has `aluop`=01, `pcwritecond`=1, `pcsource`=01. Count reaches 2 after 7 cycles.
- sw with `mem_ready` low for 3 cycles in MEMWR: `memwrite`=1 for 4 cycles, then FETCH. Total 7 cycles; count +1.
- Opcode 001000 (addi, unsupported): states 0,1,10,0. `aluop`=11 and `illegal`=1 in one cycle only; count unchanged; no write enables asserted.
- `COUNT_W`=4, 16 j instructions: count wraps to 0. `pcwrite`=1 with `pcsource`=10 in every JUMP cycle.
